skew_read_sequencer: RTL and testbench

- Read-side controller for the per-lane memory array feeding the systolic array.
- Generates per-lane rd_en and 8-bit rd_addr, diagonally skewed: lane i issues the same address sequence as lane 0, delayed by i cycles.
- Runs one burst of num_rows consecutive row addresses per start; reports busy/done.
- Output buses connect directly to the memory array's rd_en / rd_addr ports.

---
 rtl/skew_read_sequencer.sv | 153 +++++++++++++++
 tb/tb_skew_read_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/skew_read_sequencer.sv
// skew_read_sequencer: read-side sequencer for the per-lane memory array that
// feeds the systolic array. A lane-0 generator emits num_rows consecutive row
// addresses per start. A registered (en, addr) delay chain replays that
// sequence on lane i exactly i cycles later.
// Optional feature: define SKEW_READ_STRIDE_EN to add the addr_stride input.
// Without it the address step is fixed at 1.
module skew_read_sequencer #(
  parameter int unsigned width_height = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [7:0]                  base_addr,
  input  logic [7:0]                  num_rows,
`ifdef SKEW_READ_STRIDE_EN
  input  logic [7:0]                  addr_stride,
`endif
  input  logic                        stall,
  output logic [width_height-1:0]     rd_en,
  output logic [width_height*8-1:0]   rd_addr,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // DRAIN lasts width_height-1 cycles, counted down to zero.
  localparam logic [7:0] DRAIN_INIT = (width_height > 1) ? 8'(width_height - 2) : '0;

  state_t                          state_q, state_d;
  logic [7:0]                      cnt_q, cnt_d;
  logic [7:0]                      drain_q, drain_d;
  logic [width_height-1:0]         en_q, en_d;
  logic [width_height-1:0][7:0]    addr_q, addr_d;
  logic [7:0]                      stride_w;
  logic                            active;

`ifdef SKEW_READ_STRIDE_EN
  logic [7:0]                      stride_q, stride_d;
  assign stride_w = stride_q;
`else
  assign stride_w = 8'd1;
`endif

  assign active = (state_q == S_RUN) || (state_q == S_DRAIN);

  // Next-state, lane-0 generator and delay-chain shift; everything holds while stalled in a burst
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    en_d     = en_q;
    addr_d   = addr_q;
`ifdef SKEW_READ_STRIDE_EN
    stride_d = stride_q;
`endif

    if (!(active && stall)) begin
      for (int unsigned i = 1; i < width_height; i++) begin
        en_d[i]   = en_q[i-1];
        addr_d[i] = addr_q[i-1];
      end
    end

    case (state_q)
      S_IDLE: begin
        en_d[0] = 1'b0;
        if (start) begin
          if (num_rows != 8'd0) begin
            state_d   = S_RUN;
            en_d[0]   = 1'b1;
            addr_d[0] = base_addr;
            cnt_d     = num_rows - 8'd1;
`ifdef SKEW_READ_STRIDE_EN
            stride_d  = addr_stride;
`endif
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (cnt_q != 8'd0) begin
            addr_d[0] = addr_q[0] + stride_w;
            cnt_d     = cnt_q - 8'd1;
          end else begin
            en_d[0] = 1'b0;
            drain_d = DRAIN_INIT;
            state_d = (width_height == 1) ? S_DONE : S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!stall) begin
          if (drain_q == 8'd0) begin
            state_d = S_DONE;
          end else begin
            drain_d = drain_q - 8'd1;
          end
        end
      end
      S_DONE: begin
        en_d[0] = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and delay-chain registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      drain_q  <= '0;
      en_q     <= '0;
      addr_q   <= '0;
`ifdef SKEW_READ_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      en_q     <= en_d;
      addr_q   <= addr_d;
`ifdef SKEW_READ_STRIDE_EN
      stride_q <= stride_d;
`endif
    end
  end

  // Stall masks enables combinationally; the chain itself is frozen by the hold above
  always_comb begin
    rd_en = '0;
    if (active) begin
      rd_en = en_q & ~{width_height{stall}};
    end
  end

  assign rd_addr = addr_q;
  assign busy    = active;
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_skew_read_sequencer.sv
// Scoreboard bench for skew_read_sequencer: stimulus pushes expected per-lane
// reads, done cycles and busy windows; a negedge monitor pops and compares.
module tb_skew_read_sequencer;

  localparam int W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [7:0]       base_addr = '0;
  logic [7:0]       num_rows = '0;
  logic             stall = 1'b0;
  logic [W-1:0]     rd_en;
  logic [W*8-1:0]   rd_addr;
  logic             busy;
  logic             done;
`ifdef SKEW_READ_STRIDE_EN
  logic [7:0]       addr_stride = 8'd1;
`endif

  skew_read_sequencer #(.width_height(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .num_rows(num_rows),
`ifdef SKEW_READ_STRIDE_EN
    .addr_stride(addr_stride),
`endif
    .stall(stall),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         lane;
    int         cyc;
    logic [7:0] addr;
  } ev_t;

  ev_t ev_q[$];
  int  done_q[$];
  int  busy_lo = 1;
  int  busy_hi = 0;
  int  total = 0;
  int  bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: every observed read must match a queued expectation for that lane and cycle
  always @(negedge clk) begin : monitor
    int idx;
    for (int i = 0; i < W; i++) begin
      if (rd_en[i]) begin
        idx = -1;
        for (int j = 0; j < ev_q.size(); j++)
          if (ev_q[j].lane == i && ev_q[j].cyc == cyc) idx = j;
        if (idx < 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rd lane %0d at cyc %0d: got rd_en=1 addr 0x%0h expected rd_en=0",
                   i, cyc, rd_addr[i*8 +: 8]);
        end else begin
          chk($sformatf("rd_addr_lane%0d", i), 32'(rd_addr[i*8 +: 8]), 32'(ev_q[idx].addr));
          ev_q.delete(idx);
        end
      end
    end
    chk("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
    if (done) begin
      if (done_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done at cyc %0d: got done=1 expected done=0", cyc);
      end else begin
        chk("done_cyc", 32'(cyc), 32'(done_q.pop_front()));
      end
    end
  end

  // Issue one start and queue the expected reads; stall_mode models the stall in cycles 2-3
  task automatic start_burst(input logic [7:0] base, input logic [7:0] n, input logic [7:0] stride,
                             input bit stall_mode, input int cutoff_rel, output int s);
    int adj;
    int c;
    logic [7:0] a;
    @(negedge clk);
    s = cyc;
    start = 1'b1;
    base_addr = base;
    num_rows = n;
`ifdef SKEW_READ_STRIDE_EN
    addr_stride = stride;
`endif
    for (int i = 0; i < W; i++) begin
      a = base;
      for (int k = 0; k < int'(n); k++) begin
        adj = (stall_mode && (k + i) >= 1) ? 2 : 0;
        c = s + 1 + k + i + adj;
        if (c <= s + cutoff_rel) ev_q.push_back('{lane: i, cyc: c, addr: a});
`ifdef SKEW_READ_STRIDE_EN
        a = a + stride;
`else
        a = a + 8'd1;
`endif
      end
    end
    adj = stall_mode ? 2 : 0;
    if (n == 0) begin
      if (1 <= cutoff_rel) done_q.push_back(s + 1);
      busy_lo = 1;
      busy_hi = 0;
    end else begin
      if (int'(n) + W + adj <= cutoff_rel) done_q.push_back(s + int'(n) + W + adj);
      busy_lo = s + 1;
      busy_hi = s + int'(n) + W - 1 + adj;
      if (busy_hi > s + cutoff_rel) busy_hi = s + cutoff_rel;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic end_check(input string nm);
    chk({nm, "_reads_left"}, 32'(ev_q.size()), 32'd0);
    chk({nm, "_done_left"}, 32'(done_q.size()), 32'd0);
    ev_q.delete();
    done_q.delete();
  endtask

  initial begin
    int s;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", rd_addr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // base 0x10, 3 rows
    start_burst(8'h10, 8'd3, 8'd1, 1'b0, 1000, s);
    repeat (3 + W + 4) @(negedge clk);
    end_check("basic");

    // address wrap past 0xFF
    start_burst(8'hFE, 8'd4, 8'd1, 1'b0, 1000, s);
    repeat (4 + W + 4) @(negedge clk);
    end_check("wrap");

    // zero rows: done in cycle 1 only, no reads
    start_burst(8'h33, 8'd0, 8'd1, 1'b0, 1000, s);
    repeat (5) @(negedge clk);
    end_check("zero");

    // stall during cycles 2-3
    start_burst(8'h00, 8'd3, 8'd1, 1'b1, 1000, s);
    @(posedge clk);
    #1 stall = 1'b1;
    repeat (2) @(posedge clk);
    #1 stall = 1'b0;
    repeat (3 + W + 6) @(negedge clk);
    end_check("stall");

    // start re-asserted mid-burst, then reset in cycle 4
    start_burst(8'h10, 8'd3, 8'd1, 1'b0, 3, s);
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    base_addr = 8'h80;
    @(posedge clk);
    #1 reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_rd_en", 32'(rd_en), 32'd0);
    chk("abort_rd_addr", rd_addr, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    end_check("abort");

    // fresh burst after reset
    start_burst(8'h40, 8'd2, 8'd1, 1'b0, 1000, s);
    repeat (2 + W + 4) @(negedge clk);
    end_check("post_reset");

`ifdef SKEW_READ_STRIDE_EN
    // stride 4
    start_burst(8'h00, 8'd3, 8'd4, 1'b0, 1000, s);
    repeat (3 + W + 4) @(negedge clk);
    end_check("stride");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
